prog_store: RTL and testbench
=============================

// Module: prog_store
// PURPOSE
//  Program memory and byte-serial loader on the instruction-fetch side of the washer processor.
//  Accepts a framed byte stream (count, instruction words, checksum) and writes it into an internal word array.
//  Serves instr combinationally for the processor's pc, and holds the processor in reset until a valid program is loaded.
// PARAMETERS
//  INSTRS_WIDTH  32   instruction word width; fixed at 4 bytes
//  ADDR_WIDTH    8    pc / word address width
//  DEPTH         256  words of storage, 2**ADDR_WIDTH
// PORTS
//  clk        in   1   sole clock
//  rst        in   1   synchronous, active-high reset
//  ld_start   in   1   pulse: begin or restart a program load
//  ld_valid   in   1   ld_byte is valid
//  ld_byte    in   8   load stream byte
//  ld_ready   out  1   loader can accept a byte; transfer happens when ld_valid & ld_ready
//  ld_done    out  1   a valid program is resident (RUN state)
//  ld_err     out  1   last load failed; sticky until the next ld_start
//  pc         in   ADDR_WIDTH      processor fetch address
//  instr      out  INSTRS_WIDTH    instruction at pc, combinational
//  cpu_rst_n  out  1   processor reset, active-low; low whenever the state is not RUN
//  cpu_ena    out  1   processor enable; equal to ld_done
// BEHAVIOUR
//  Reset: state=IDLE, word_cnt=0, wr_addr=0, byte_idx=0, csum=0.
//   Outputs: ld_ready=0, ld_done=0, ld_err=0, cpu_rst_n=0, cpu_ena=0, instr=0.
//   Memory array contents are not reset.
//  FSM states: IDLE, COUNT, DATA, CHECK, RUN, ERR.
//   IDLE/RUN/ERR: ld_start -> COUNT; clear csum, wr_addr, byte_idx and ld_err.
//   COUNT: accept 1 byte N.
//    N==0 -> ERR.
//    Else word_cnt<=N and go to DATA.
//    Max program size is 255 words.
//   DATA: accept bytes little-endian, byte 0 -> instr[7:0] (opcode), byte 3 -> instr[31:24].
//    On the 4th byte, write the assembled word to mem[wr_addr] in the same cycle, then wr_addr++ and byte_idx=0.
//    After word N-1 is written -> CHECK.
//   CHECK: accept 1 byte.
//    Equal to csum -> RUN.
//    Otherwise -> ERR.
//   ERR: ld_err=1, word_cnt<=0; the memory keeps the partial writes.
//  csum: 8-bit XOR of every DATA byte; the count byte and the checksum byte are excluded.
//  ld_ready=1 only in COUNT, DATA and CHECK.
//   A byte is consumed only on ld_valid&ld_ready.
//   ld_valid without ld_ready is ignored and produces no error.
//  ld_start while in COUNT/DATA/CHECK aborts the load and restarts COUNT.
//   A byte offered in the same cycle is dropped.
//   ld_start has priority over a byte transfer.
//  instr:
//   = mem[pc] when state==RUN and pc < word_cnt.
//   = 0 (halt opcode 0x00) when pc >= word_cnt or state != RUN.
//   There is no fetch latency: the processor consumes instr in the cycle pc is presented.
//  cpu_rst_n rises one cycle after entering RUN, so the processor restarts from pc=0 on every successful load.
//  rst during a load behaves as reset: IDLE, processor held in reset.
//  wr_addr never wraps, because N <= 255 < DEPTH.
// STRUCTURE
//  Shared package: state encoding, the 4-bytes-per-word constant, and HALT_OPCODE=8'h00 (shared with the processor's opcode table).
//  Sub-module prog_mem: word array with 1 synchronous write port and 1 asynchronous read port.
//  The FSM, byte assembler and checksum stay in prog_store.
// TESTING
//  Reset, then stream 02, 21 00 05 00, 00 00 00 00, csum 24 -> ld_done=1.
//   pc=0 gives instr=32'h0005_0021; pc=1 gives 0; pc=2 gives 0 (beyond count).
//  Same load with checksum byte 25 -> ld_err=1, ld_done=0, cpu_rst_n=0, instr=0 for all pc.
//  Count byte 00 -> ERR after 1 byte; ld_ready=0 afterwards.
//  ld_valid toggled randomly, with ld_ready observed low in IDLE -> only handshaken bytes are counted.
//   Loaded words match the reference stream.
//  ld_start asserted mid-DATA (after 5 bytes), then a full valid 1-word stream -> RUN.
//   mem[0] holds the new word.
//  rst asserted during CHECK -> IDLE next cycle with all outputs at their reset values.
//   A subsequent load succeeds.

Source files
------------

// File: rtl/prog_store_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_store_pkg
// Brief    : Shared types and constants for the program store and its loader.
// Revision : 1.0
// ============================================================================
package prog_store_pkg;

    localparam int          c_BYTES_PER_WORD = 4;
    // Shared with the processor's opcode table: an all-zero word halts the core.
    localparam logic [7:0]  HALT_OPCODE      = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_store_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_store_if
// Brief    : Loader byte stream and instruction-fetch signals of the program store.
// Revision : 1.0
// ============================================================================
interface prog_store_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int INSTRS_WIDTH = 32
);
    logic                    ld_start;
    logic                    ld_valid;
    logic [7:0]              ld_byte;
    logic                    ld_ready;
    logic                    ld_done;
    logic                    ld_err;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [INSTRS_WIDTH-1:0] instr;
    logic                    cpu_rst_n;
    logic                    cpu_ena;

    modport master (
        output ld_start, ld_valid, ld_byte, pc,
        input  ld_ready, ld_done, ld_err, instr, cpu_rst_n, cpu_ena
    );

    modport slave (
        input  ld_start, ld_valid, ld_byte, pc,
        output ld_ready, ld_done, ld_err, instr, cpu_rst_n, cpu_ena
    );
endinterface
`default_nettype wire

// File: rtl/prog_store_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem
// Brief    : Word array, one synchronous write port, one asynchronous read port.
// Revision : 1.0
// ============================================================================
module prog_mem #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]      i_wdata,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output logic      [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/prog_store.sv
`default_nettype none
// ============================================================================
// Module   : prog_store
// Brief    : Program memory with framed byte-serial loader; holds the processor
//            in reset until a checksum-verified program is resident.
// Revision : 1.0
// ============================================================================
module prog_store
    import prog_store_pkg::*;
#(
    parameter int INSTRS_WIDTH = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 2**ADDR_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prog_store_if.slave bus
);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_word_cnt;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [1:0]              r_byte_idx;
    logic [7:0]              r_csum;
    logic [INSTRS_WIDTH-9:0] r_asm;
    logic                    r_ld_err;
    logic                    r_cpu_rst_n;

    logic                    w_ld_ready;
    logic                    w_xfer;
    logic                    w_mem_we;
    logic                    w_fetch_ok;
    logic [INSTRS_WIDTH-1:0] w_wdata;
    logic [INSTRS_WIDTH-1:0] w_rdata;

    assign w_ld_ready = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    // A restart wins over a byte offered in the same cycle.
    assign w_xfer     = bus.ld_valid && w_ld_ready && !bus.ld_start;
    assign w_mem_we   = w_xfer && (r_state == ST_DATA) && (r_byte_idx == 2'd3);
    assign w_wdata    = {bus.ld_byte, r_asm};

    prog_mem #(
        .WIDTH      (INSTRS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_addr),
        .i_wdata (w_wdata),
        .i_raddr (bus.pc),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_wr_addr   <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
            r_asm       <= '0;
            r_ld_err    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            // Release lags entry into RUN by one cycle so the core restarts at pc=0.
            r_cpu_rst_n <= (r_state == ST_RUN) && !bus.ld_start;

            if (bus.ld_start) begin
                r_state    <= ST_COUNT;
                r_csum     <= '0;
                r_wr_addr  <= '0;
                r_byte_idx <= '0;
                r_ld_err   <= 1'b0;
            end else if (w_xfer) begin
                unique case (r_state)
                    ST_COUNT: begin
                        if (bus.ld_byte == 8'd0) begin
                            r_state    <= ST_ERR;
                            r_ld_err   <= 1'b1;
                            r_word_cnt <= '0;
                        end else begin
                            r_word_cnt <= ADDR_WIDTH'(bus.ld_byte);
                            r_state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_csum <= csum_step(r_csum, bus.ld_byte);
                        unique case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= bus.ld_byte;
                            2'd1: r_asm[15:8]  <= bus.ld_byte;
                            2'd2: r_asm[23:16] <= bus.ld_byte;
                            default: ;
                        endcase
                        if (r_byte_idx == 2'd3) begin
                            r_byte_idx <= '0;
                            r_wr_addr  <= r_wr_addr + 1'b1;
                            if (r_wr_addr == r_word_cnt - 1'b1) begin
                                r_state <= ST_CHECK;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (bus.ld_byte == r_csum) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state    <= ST_ERR;
                            r_ld_err   <= 1'b1;
                            r_word_cnt <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_fetch_ok    = (r_state == ST_RUN) && (bus.pc < r_word_cnt);
    assign bus.instr     = w_fetch_ok ? w_rdata : {{(INSTRS_WIDTH-8){1'b0}}, HALT_OPCODE};
    assign bus.ld_ready  = w_ld_ready;
    assign bus.ld_done   = (r_state == ST_RUN);
    assign bus.cpu_ena   = (r_state == ST_RUN);
    assign bus.ld_err    = r_ld_err;
    assign bus.cpu_rst_n = r_cpu_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_prog_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_store
// Brief    : Directed self-checking bench for prog_store.
// Revision : 1.0
// ============================================================================
module tb_prog_store;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    prog_store_if u_bus ();

    prog_store u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while (!u_bus.ld_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!u_bus.ld_ready) begin
            check_value("ready_timeout", {31'd0, u_bus.ld_ready}, 32'd1);
            return;
        end
        u_bus.ld_valid = 1'b1;
        u_bus.ld_byte  = b;
        tick();
        u_bus.ld_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic start_load();
        u_bus.ld_start = 1'b1;
        tick();
        u_bus.ld_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        u_bus.pc = 8'd0;
        #1;
        check_value({tag, "_ready"},     {31'd0, u_bus.ld_ready},  32'd0);
        check_value({tag, "_done"},      {31'd0, u_bus.ld_done},   32'd0);
        check_value({tag, "_err"},       {31'd0, u_bus.ld_err},    32'd0);
        check_value({tag, "_cpu_rst_n"}, {31'd0, u_bus.cpu_rst_n}, 32'd0);
        check_value({tag, "_cpu_ena"},   {31'd0, u_bus.cpu_ena},   32'd0);
        check_value({tag, "_instr"},     u_bus.instr,              32'd0);
    endtask

    task automatic check_instr(input string tag, input logic [7:0] pc, input logic [31:0] exp);
        u_bus.pc = pc;
        #1;
        check_value(tag, u_bus.instr, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s_good[$];
        logic [7:0] s_bad[$];
        logic [7:0] s_one[$];
        logic [7:0] s_rand[$];
        int         idx;
        logic       v;
        logic       r;

        s_good = '{8'h02, 8'h21, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h24};
        s_bad  = '{8'h02, 8'h21, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h25};
        s_one  = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        s_rand = '{8'h03, 8'h44, 8'h33, 8'h22, 8'h11, 8'h5A, 8'h5A, 8'hA5, 8'hA5,
                   8'hFF, 8'h00, 8'h00, 8'h00, 8'hBB};

        u_bus.ld_start = 1'b0;
        u_bus.ld_valid = 1'b0;
        u_bus.ld_byte  = 8'h00;
        u_bus.pc       = 8'd0;
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Good two-word load.
        start_load();
        send_stream(s_good);
        check_value("good_done",         {31'd0, u_bus.ld_done},   32'd1);
        check_value("good_err",          {31'd0, u_bus.ld_err},    32'd0);
        check_value("good_ready",        {31'd0, u_bus.ld_ready},  32'd0);
        check_value("good_rst_n_delay",  {31'd0, u_bus.cpu_rst_n}, 32'd0);
        tick();
        check_value("good_rst_n",        {31'd0, u_bus.cpu_rst_n}, 32'd1);
        check_value("good_ena",          {31'd0, u_bus.cpu_ena},   32'd1);
        check_instr("good_pc0", 8'd0, 32'h0005_0021);
        check_instr("good_pc1", 8'd1, 32'h0000_0000);
        check_instr("good_pc2", 8'd2, 32'h0000_0000);

        // Bad checksum.
        start_load();
        check_value("restart_rst_n", {31'd0, u_bus.cpu_rst_n}, 32'd0);
        send_stream(s_bad);
        tick();
        check_value("bad_err",   {31'd0, u_bus.ld_err},    32'd1);
        check_value("bad_done",  {31'd0, u_bus.ld_done},   32'd0);
        check_value("bad_rst_n", {31'd0, u_bus.cpu_rst_n}, 32'd0);
        check_value("bad_ready", {31'd0, u_bus.ld_ready},  32'd0);
        for (int p = 0; p < 3; p++) check_instr("bad_instr", 8'(p), 32'd0);

        // Zero count.
        start_load();
        check_value("zero_err_cleared", {31'd0, u_bus.ld_err}, 32'd0);
        send_byte(8'h00);
        check_value("zero_err",   {31'd0, u_bus.ld_err},   32'd1);
        check_value("zero_ready", {31'd0, u_bus.ld_ready}, 32'd0);

        // Random ld_valid: ignored in IDLE, only handshaken bytes count.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            u_bus.ld_valid = 1'($urandom_range(0, 1));
            u_bus.ld_byte  = 8'($urandom);
            check_value("idle_ready", {31'd0, u_bus.ld_ready}, 32'd0);
            tick();
        end
        u_bus.ld_valid = 1'b0;
        check_value("idle_err",  {31'd0, u_bus.ld_err},  32'd0);
        check_value("idle_done", {31'd0, u_bus.ld_done}, 32'd0);
        start_load();
        idx = 0;
        for (int c = 0; c < 400 && idx < s_rand.size(); c++) begin
            v = 1'($urandom_range(0, 1));
            u_bus.ld_valid = v;
            u_bus.ld_byte  = v ? s_rand[idx] : 8'($urandom);
            r = u_bus.ld_ready;
            tick();
            if (v && r) idx++;
        end
        u_bus.ld_valid = 1'b0;
        check_value("rand_len",  idx, s_rand.size());
        check_value("rand_done", {31'd0, u_bus.ld_done}, 32'd1);
        check_instr("rand_pc0", 8'd0, 32'h1122_3344);
        check_instr("rand_pc1", 8'd1, 32'hA5A5_5A5A);
        check_instr("rand_pc2", 8'd2, 32'h0000_00FF);
        check_instr("rand_pc3", 8'd3, 32'h0000_0000);

        // Abort mid-DATA with a byte offered alongside ld_start.
        start_load();
        send_stream('{8'h02, 8'h21, 8'h00, 8'h05, 8'h00});
        u_bus.ld_start = 1'b1;
        u_bus.ld_valid = 1'b1;
        u_bus.ld_byte  = 8'h77;
        tick();
        u_bus.ld_start = 1'b0;
        u_bus.ld_valid = 1'b0;
        check_value("abort_ready", {31'd0, u_bus.ld_ready}, 32'd1);
        send_stream(s_one);
        check_value("abort_done", {31'd0, u_bus.ld_done}, 32'd1);
        tick();
        check_instr("abort_pc0", 8'd0, 32'hEFBE_ADDE);
        check_instr("abort_pc1", 8'd1, 32'h0000_0000);

        // Reset while waiting for the checksum byte.
        start_load();
        send_stream('{8'h02, 8'h21, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        check_value("check_ready", {31'd0, u_bus.ld_ready}, 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_check");
        rst = 1'b0;
        start_load();
        send_stream(s_one);
        check_value("reload_done", {31'd0, u_bus.ld_done}, 32'd1);
        tick();
        check_value("reload_rst_n", {31'd0, u_bus.cpu_rst_n}, 32'd1);
        check_instr("reload_pc0", 8'd0, 32'hEFBE_ADDE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
